// File: rtl/mem_rd_sequencer_pkg.sv
// Shared pipeline definitions for the memory-read sequencer: state encoding,
// rw bit positions and the first-state decode used at operand capture.
package mem_rd_sequencer_pkg;

   localparam int READ_BIT  = 0;
   localparam int WRITE_BIT = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD1   = 3'd1,
      RD2   = 3'd2,
      HOLD  = 3'd3,
      DRAIN = 3'd4
   } state_e;

   function automatic state_e first_state(input logic [1:0] rw1, input logic [1:0] rw2);
      if (rw1[READ_BIT]) return RD1;
      if (rw2[READ_BIT]) return RD2;
      return HOLD;
   endfunction

endpackage

// File: rtl/regn.sv
// Generic W-bit register with synchronous clear (priority) and load enable.
module regn #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         ld,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] val_q, val_d;

   always_comb begin
      val_d = val_q;
      if (clr)     val_d = '0;
      else if (ld) val_d = d;
   end

   always_ff @(posedge clk) val_q <= val_d;

   assign q = val_q;

endmodule

// File: rtl/mem_rd_sequencer.sv
// Sequences up to two cache reads per memory op from the RrAg_MEM latch and
// presents both operands downstream with a valid/ready handshake.
module mem_rd_sequencer
   import mem_rd_sequencer_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              valid_in,
   input  logic [1:0]        opsize_in,
   input  logic [ADDR_W-1:0] mem_addr1_in,
   input  logic [ADDR_W-1:0] mem_addr2_in,
   input  logic [1:0]        mem1_rw_in,
   input  logic [1:0]        mem2_rw_in,
   output logic              latch_ld_out,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [1:0]        rd_size,
   input  logic              rd_ack,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] mem1_data_out,
   output logic [DATA_W-1:0] mem2_data_out,
   input  logic              flush
);

   state_e            state_q, state_d;
   logic              drain_sel_q, drain_sel_d;
   logic              cap, ld1, ld2, dclr;
   logic [ADDR_W-1:0] addr1_q, addr2_q;
   logic [1:0]        opsize_q;
   logic [3:0]        rw_q;
   logic              unused_rw;

   regn #(.W(ADDR_W)) u_addr1  (.clk(clk), .clr(clr), .ld(cap), .d(mem_addr1_in), .q(addr1_q));
   regn #(.W(ADDR_W)) u_addr2  (.clk(clk), .clr(clr), .ld(cap), .d(mem_addr2_in), .q(addr2_q));
   regn #(.W(2))      u_opsize (.clk(clk), .clr(clr), .ld(cap), .d(opsize_in),    .q(opsize_q));
   regn #(.W(4))      u_rw     (.clk(clk), .clr(clr), .ld(cap), .d({mem2_rw_in, mem1_rw_in}), .q(rw_q));

   // Each capture zeroes both operands so an unread operand presents as 0.
   assign dclr = clr | cap;
   regn #(.W(DATA_W)) u_data1 (.clk(clk), .clr(dclr), .ld(ld1), .d(rd_data), .q(mem1_data_out));
   regn #(.W(DATA_W)) u_data2 (.clk(clk), .clr(dclr), .ld(ld2), .d(rd_data), .q(mem2_data_out));

   // Only operand 2's read bit steers the sequence after capture; the rest is kept for the op record.
   assign unused_rw = ^{rw_q[WRITE_BIT], rw_q[READ_BIT], rw_q[2 + WRITE_BIT]};

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= IDLE;
         drain_sel_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_sel_q <= drain_sel_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      drain_sel_d = drain_sel_q;
      case (state_q)
         IDLE: begin
            if (!flush && valid_in) state_d = first_state(mem1_rw_in, mem2_rw_in);
         end
         RD1: begin
            if (flush) begin
               state_d     = rd_ack ? IDLE : DRAIN;
               drain_sel_d = 1'b0;
            end else if (rd_ack) begin
               state_d = rw_q[2 + READ_BIT] ? RD2 : HOLD;
            end
         end
         RD2: begin
            if (flush) begin
               state_d     = rd_ack ? IDLE : DRAIN;
               drain_sel_d = 1'b1;
            end else if (rd_ack) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (flush)          state_d = IDLE;
            else if (out_ready) state_d = valid_in ? first_state(mem1_rw_in, mem2_rw_in) : IDLE;
         end
         DRAIN: begin
            if (rd_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The in-flight request stays on the bus through DRAIN until the cache acks it.
   always_comb begin
      latch_ld_out = clr;
      rd_req       = 1'b0;
      rd_addr      = '0;
      rd_size      = 2'b00;
      out_valid    = 1'b0;
      cap          = 1'b0;
      ld1          = 1'b0;
      ld2          = 1'b0;
      case (state_q)
         IDLE: begin
            latch_ld_out = 1'b1;
            cap          = valid_in & ~flush & ~clr;
         end
         RD1: begin
            rd_req  = 1'b1;
            rd_addr = addr1_q;
            rd_size = opsize_q;
            ld1     = rd_ack & ~flush;
         end
         RD2: begin
            rd_req  = 1'b1;
            rd_addr = addr2_q;
            rd_size = opsize_q;
            ld2     = rd_ack & ~flush;
         end
         HOLD: begin
            out_valid    = 1'b1;
            latch_ld_out = clr | out_ready;
            cap          = out_ready & valid_in & ~flush & ~clr;
         end
         DRAIN: begin
            rd_req       = 1'b1;
            rd_addr      = drain_sel_q ? addr2_q : addr1_q;
            rd_size      = opsize_q;
            latch_ld_out = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_rd_sequencer.sv
// Directed bench for mem_rd_sequencer: reads, holds, back-to-back capture,
// flush/drain, reset mid-read and write-only pass-through.
module tb_mem_rd_sequencer;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;

   logic              clk = 1'b0;
   logic              clr, valid_in, rd_ack, out_ready, flush;
   logic [1:0]        opsize_in, mem1_rw_in, mem2_rw_in;
   logic [ADDR_W-1:0] mem_addr1_in, mem_addr2_in;
   logic              latch_ld_out, rd_req, out_valid;
   logic [ADDR_W-1:0] rd_addr;
   logic [1:0]        rd_size;
   logic [DATA_W-1:0] rd_data, mem1_data_out, mem2_data_out;

   int n_chk  = 0;
   int n_fail = 0;

   mem_rd_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .clr(clr), .valid_in(valid_in), .opsize_in(opsize_in),
      .mem_addr1_in(mem_addr1_in), .mem_addr2_in(mem_addr2_in),
      .mem1_rw_in(mem1_rw_in), .mem2_rw_in(mem2_rw_in),
      .latch_ld_out(latch_ld_out), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_size(rd_size), .rd_ack(rd_ack), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .mem1_data_out(mem1_data_out), .mem2_data_out(mem2_data_out),
      .flush(flush)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      valid_in  = 1'b0;
      flush     = 1'b0;
      rd_ack    = 1'b0;
      out_ready = 1'b0;
      rd_data   = '0;
   endtask

   task automatic issue(input logic [31:0] a1, input logic [31:0] a2,
                        input logic [1:0] sz, input logic [1:0] r1, input logic [1:0] r2);
      valid_in     = 1'b1;
      mem_addr1_in = a1;
      mem_addr2_in = a2;
      opsize_in    = sz;
      mem1_rw_in   = r1;
      mem2_rw_in   = r2;
   endtask

   initial begin
      quiet();
      clr = 1'b1;
      opsize_in = 2'b00; mem1_rw_in = 2'b00; mem2_rw_in = 2'b00;
      mem_addr1_in = '0; mem_addr2_in = '0;
      tick(); tick();
      chk("rst_ld_during", 64'(latch_ld_out), 64'd1);
      clr = 1'b0;
      #1;
      chk("rst_rd_req", 64'(rd_req), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_rd_addr", 64'(rd_addr), 64'd0);
      chk("rst_rd_size", 64'(rd_size), 64'd0);
      chk("rst_mem1", mem1_data_out, 64'd0);
      chk("rst_mem2", mem2_data_out, 64'd0);
      chk("rst_ld_after", 64'(latch_ld_out), 64'd1);

      // both operands read: RD1 ack one cycle after req, RD2 ack immediate
      issue(32'h1000, 32'h2000, 2'd3, 2'b01, 2'b01);
      #1 chk("s1_c0_ld", 64'(latch_ld_out), 64'd1);
      tick(); quiet();
      chk("s1_c1_req", 64'(rd_req), 64'd1);
      chk("s1_c1_addr", 64'(rd_addr), 64'h1000);
      chk("s1_c1_size", 64'(rd_size), 64'd3);
      chk("s1_c1_ld", 64'(latch_ld_out), 64'd0);
      tick();
      rd_ack = 1'b1; rd_data = 64'hAAAA_AAAA_AAAA_AAAA;
      #1 chk("s1_c2_addr", 64'(rd_addr), 64'h1000);
      chk("s1_c2_ld", 64'(latch_ld_out), 64'd0);
      tick();
      rd_data = 64'hBBBB_BBBB_BBBB_BBBB;
      #1 chk("s1_c3_req", 64'(rd_req), 64'd1);
      chk("s1_c3_addr", 64'(rd_addr), 64'h2000);
      chk("s1_c3_ld", 64'(latch_ld_out), 64'd0);
      chk("s1_c3_nvalid", 64'(out_valid), 64'd0);
      tick(); quiet();
      chk("s1_c4_valid", 64'(out_valid), 64'd1);
      chk("s1_c4_req", 64'(rd_req), 64'd0);
      chk("s1_c4_mem1", mem1_data_out, 64'hAAAA_AAAA_AAAA_AAAA);
      chk("s1_c4_mem2", mem2_data_out, 64'hBBBB_BBBB_BBBB_BBBB);
      out_ready = 1'b1;
      #1 chk("s1_c4_ld", 64'(latch_ld_out), 64'd1);
      tick(); quiet();
      chk("s1_idle_valid", 64'(out_valid), 64'd0);

      // operand 1 only, immediate ack; then hold for 5 cycles and back-to-back capture
      issue(32'h3000, 32'h3100, 2'd2, 2'b01, 2'b10);
      tick(); quiet();
      rd_ack = 1'b1; rd_data = 64'h1111_2222_3333_4444;
      #1 chk("s2_c1_req", 64'(rd_req), 64'd1);
      chk("s2_c1_addr", 64'(rd_addr), 64'h3000);
      tick(); quiet();
      chk("s2_c2_valid", 64'(out_valid), 64'd1);
      chk("s2_c2_mem1", mem1_data_out, 64'h1111_2222_3333_4444);
      chk("s2_c2_mem2", mem2_data_out, 64'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("s3_hold_valid", 64'(out_valid), 64'd1);
         chk("s3_hold_mem1", mem1_data_out, 64'h1111_2222_3333_4444);
         chk("s3_hold_mem2", mem2_data_out, 64'd0);
         chk("s3_hold_ld", 64'(latch_ld_out), 64'd0);
      end
      out_ready = 1'b1;
      issue(32'h0, 32'h4000, 2'd1, 2'b00, 2'b01);
      #1 chk("s3_b2b_ld", 64'(latch_ld_out), 64'd1);
      tick(); quiet();
      chk("s3_b2b_req", 64'(rd_req), 64'd1);
      chk("s3_b2b_addr", 64'(rd_addr), 64'h4000);
      chk("s3_b2b_nvalid", 64'(out_valid), 64'd0);
      rd_ack = 1'b1; rd_data = 64'h5555_6666_7777_8888;
      tick(); quiet();
      chk("s3_b2b_valid", 64'(out_valid), 64'd1);
      chk("s3_b2b_mem2", mem2_data_out, 64'h5555_6666_7777_8888);
      chk("s3_b2b_mem1", mem1_data_out, 64'd0);
      out_ready = 1'b1;
      tick(); quiet();

      // flush in RD1, ack three cycles later, valid_in ignored while draining
      issue(32'h6000, 32'h6100, 2'd1, 2'b01, 2'b01);
      tick(); quiet();
      flush = 1'b1;
      #1 chk("s4_rd1_req", 64'(rd_req), 64'd1);
      tick(); quiet();
      issue(32'h6200, 32'h6300, 2'd0, 2'b01, 2'b01);
      #1 chk("s4_drain_req", 64'(rd_req), 64'd1);
      chk("s4_drain_addr", 64'(rd_addr), 64'h6000);
      chk("s4_drain_ld", 64'(latch_ld_out), 64'd1);
      chk("s4_drain_nvalid", 64'(out_valid), 64'd0);
      tick();
      chk("s4_drain2_req", 64'(rd_req), 64'd1);
      quiet();
      rd_ack = 1'b1; rd_data = 64'hDEAD_BEEF_DEAD_BEEF;
      tick(); quiet();
      chk("s4_idle_req", 64'(rd_req), 64'd0);
      chk("s4_idle_valid", 64'(out_valid), 64'd0);
      chk("s4_discard_mem1", mem1_data_out, 64'd0);
      tick();
      chk("s4_still_req", 64'(rd_req), 64'd0);
      chk("s4_still_valid", 64'(out_valid), 64'd0);

      // clr mid-RD2, late ack must be ignored
      issue(32'h7000, 32'h8000, 2'd3, 2'b01, 2'b01);
      tick(); quiet();
      rd_ack = 1'b1; rd_data = 64'h7777;
      tick(); quiet();
      chk("s5_rd2_addr", 64'(rd_addr), 64'h8000);
      clr = 1'b1;
      #1 chk("s5_clr_ld", 64'(latch_ld_out), 64'd1);
      tick();
      clr = 1'b0;
      rd_ack = 1'b1; rd_data = 64'h9999;
      #1 chk("s5_req", 64'(rd_req), 64'd0);
      chk("s5_addr", 64'(rd_addr), 64'd0);
      chk("s5_size", 64'(rd_size), 64'd0);
      chk("s5_valid", 64'(out_valid), 64'd0);
      chk("s5_mem1", mem1_data_out, 64'd0);
      chk("s5_mem2", mem2_data_out, 64'd0);
      tick(); quiet();
      chk("s5_late_mem2", mem2_data_out, 64'd0);
      chk("s5_late_valid", 64'(out_valid), 64'd0);

      // write-only op goes straight to HOLD
      issue(32'hA000, 32'hA100, 2'd2, 2'b10, 2'b10);
      #1 chk("s6_ld", 64'(latch_ld_out), 64'd1);
      tick(); quiet();
      chk("s6_valid", 64'(out_valid), 64'd1);
      chk("s6_req", 64'(rd_req), 64'd0);
      chk("s6_mem1", mem1_data_out, 64'd0);
      chk("s6_mem2", mem2_data_out, 64'd0);

      // flush together with out_ready in HOLD: no capture of the offered op
      flush = 1'b1; out_ready = 1'b1;
      issue(32'hB000, 32'hB100, 2'd1, 2'b01, 2'b00);
      tick(); quiet();
      chk("s7_valid", 64'(out_valid), 64'd0);
      chk("s7_req", 64'(rd_req), 64'd0);
      tick();
      chk("s7_req2", 64'(rd_req), 64'd0);

      // flush in RD1 with ack in the same cycle goes straight to IDLE
      issue(32'hC000, 32'hC100, 2'd1, 2'b01, 2'b00);
      tick(); quiet();
      flush = 1'b1; rd_ack = 1'b1; rd_data = 64'hCAFE;
      tick(); quiet();
      chk("s8_req", 64'(rd_req), 64'd0);
      chk("s8_valid", 64'(out_valid), 64'd0);
      chk("s8_mem1", mem1_data_out, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
